gshare_branch_predictor: RTL and testbench

- Parametrised global-history branch predictor, successor to the single-index m,n predictor top.
- Indexes a pattern history table (PHT) of N-bit saturating counters with the branch PC bits hashed against a global branch history register (GHR).
- Selectable hash: concatenation (m,n correlating) or XOR (gshare).
- Separate predict and resolve/update channels, registered mispredict flag, optional performance counters; sits between fetch (predict) and execute (resolve).

---
 rtl/gshare_branch_predictor.sv | 129 ++++++++++++
 tb/tb_gshare_branch_predictor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_branch_predictor.sv
// Global-history branch predictor: PHT of N-bit saturating counters indexed by PC hashed with the GHR.
// Optional performance counters are enabled by defining BP_PERF_CNT_EN.
module gshare_branch_predictor #(
    parameter int K         = 8,
    parameter int M         = 4,
    parameter int N         = 2,
    parameter int HASH_MODE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pred_valid_in,
    input  logic [K-1:0] pred_pc,
    output logic         pred_valid,
    output logic         pred_taken,
    output logic [M-1:0] pred_hist,
    input  logic         upd_valid,
    input  logic [K-1:0] upd_pc,
    input  logic [M-1:0] upd_hist,
    input  logic         upd_taken,
    output logic         upd_mispredict,
    output logic [M-1:0] ghr_out
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]  perf_branches,
    output logic [31:0]  perf_mispredicts
`endif
);

    localparam int           DEPTH    = 1 << K;
    localparam int           INIT_I   = (N == 1) ? 0 : (1 << (N - 1)) - 1;
    localparam logic [N-1:0] CNT_INIT = INIT_I[N-1:0];
    localparam logic [N-1:0] CNT_MAX  = '1;
    localparam logic [K-1:0] LOW_MASK = {K{1'b1}} >> M;

    // Concatenation keeps the low K-M PC bits under the history; with M==K the mask is empty.
    function automatic logic [K-1:0] f_index(input logic [K-1:0] p, input logic [M-1:0] h);
        logic [K-1:0] hx;
        hx = '0;
        hx[M-1:0] = h;
        if (HASH_MODE == 1)
            return p ^ hx;
        else
            return (p & LOW_MASK) | (hx << (K - M));
    endfunction

    logic [N-1:0] r_pht [DEPTH];
    logic [M-1:0] r_ghr;
    logic         r_pred_valid;
    logic         r_pred_taken;
    logic [M-1:0] r_pred_hist;
    logic         r_upd_mispredict;

    logic [K-1:0] w_pred_idx;
    logic [K-1:0] w_upd_idx;
    logic [N-1:0] w_pred_cnt;
    logic [N-1:0] w_upd_cnt;
    logic [N-1:0] w_upd_cnt_nxt;
    logic         w_upd_miss;
    logic [M:0]   w_ghr_shift;

    assign w_pred_idx  = f_index(pred_pc, r_ghr);
    assign w_upd_idx   = f_index(upd_pc, upd_hist);
    assign w_pred_cnt  = r_pht[w_pred_idx];
    assign w_upd_cnt   = r_pht[w_upd_idx];
    assign w_upd_miss  = w_upd_cnt[N-1] != upd_taken;
    assign w_ghr_shift = {r_ghr, upd_taken};

    always_comb begin
        w_upd_cnt_nxt = w_upd_cnt;
        if (upd_taken) begin
            if (w_upd_cnt != CNT_MAX)
                w_upd_cnt_nxt = w_upd_cnt + 1'b1;
        end else begin
            if (w_upd_cnt != '0)
                w_upd_cnt_nxt = w_upd_cnt - 1'b1;
        end
    end

    // Predict reads the array before this edge's update lands, giving read-before-write on collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_pht[i] <= CNT_INIT;
            r_ghr            <= '0;
            r_pred_valid     <= 1'b0;
            r_pred_taken     <= 1'b0;
            r_pred_hist      <= '0;
            r_upd_mispredict <= 1'b0;
        end else begin
            r_pred_valid     <= pred_valid_in;
            r_upd_mispredict <= upd_valid & w_upd_miss;
            if (pred_valid_in) begin
                r_pred_taken <= w_pred_cnt[N-1];
                r_pred_hist  <= r_ghr;
            end
            if (upd_valid) begin
                r_pht[w_upd_idx] <= w_upd_cnt_nxt;
                r_ghr            <= w_ghr_shift[M-1:0];
            end
        end
    end

    assign pred_valid     = r_pred_valid;
    assign pred_taken     = r_pred_taken;
    assign pred_hist      = r_pred_hist;
    assign upd_mispredict = r_upd_mispredict;
    assign ghr_out        = r_ghr;

`ifdef BP_PERF_CNT_EN
    logic [31:0] r_perf_branches;
    logic [31:0] r_perf_mispredicts;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_branches    <= '0;
            r_perf_mispredicts <= '0;
        end else if (upd_valid) begin
            if (r_perf_branches != 32'hFFFF_FFFF)
                r_perf_branches <= r_perf_branches + 32'd1;
            if (w_upd_miss && (r_perf_mispredicts != 32'hFFFF_FFFF))
                r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
        end
    end

    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed scoreboard bench: a gshare instance (HASH_MODE=1) and a concatenating instance (HASH_MODE=0)
// share one stimulus stream; each has its own expected-prediction and expected-mispredict queues.
module tb_gshare_branch_predictor;
    localparam int K = 8;
    localparam int M = 4;
    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pred_valid_in;
    logic [K-1:0] pred_pc;
    logic         upd_valid;
    logic [K-1:0] upd_pc;
    logic [M-1:0] upd_hist;
    logic         upd_taken;

    logic         a_pred_valid, b_pred_valid;
    logic         a_pred_taken, b_pred_taken;
    logic [M-1:0] a_pred_hist, b_pred_hist;
    logic         a_upd_mis, b_upd_mis;
    logic [M-1:0] a_ghr, b_ghr;
`ifdef BP_PERF_CNT_EN
    logic [31:0]  a_perf_br, a_perf_mis, b_perf_br, b_perf_mis;
    int           exp_br, exp_mis_a, exp_mis_b;
`endif

    int checks   = 0;
    int failures = 0;

    // Expected {pred_taken, pred_hist} and expected mispredict flag, per instance.
    logic [M:0] exp_pa_q[$];
    logic [M:0] exp_pb_q[$];
    logic [0:0] exp_ma_q[$];
    logic [0:0] exp_mb_q[$];

    logic d_pred, d_upd;

    always #5 clk = ~clk;

    gshare_branch_predictor #(.K(K), .M(M), .N(N), .HASH_MODE(1)) u_a (
        .clk(clk), .reset(rst_n),
        .pred_valid_in(pred_valid_in), .pred_pc(pred_pc),
        .pred_valid(a_pred_valid), .pred_taken(a_pred_taken), .pred_hist(a_pred_hist),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist), .upd_taken(upd_taken),
        .upd_mispredict(a_upd_mis), .ghr_out(a_ghr)
`ifdef BP_PERF_CNT_EN
        , .perf_branches(a_perf_br), .perf_mispredicts(a_perf_mis)
`endif
    );

    gshare_branch_predictor #(.K(K), .M(M), .N(N), .HASH_MODE(0)) u_b (
        .clk(clk), .reset(rst_n),
        .pred_valid_in(pred_valid_in), .pred_pc(pred_pc),
        .pred_valid(b_pred_valid), .pred_taken(b_pred_taken), .pred_hist(b_pred_hist),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist), .upd_taken(upd_taken),
        .upd_mispredict(b_upd_mis), .ghr_out(b_ghr)
`ifdef BP_PERF_CNT_EN
        , .perf_branches(b_perf_br), .perf_mispredicts(b_perf_mis)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bench-side record of which cycles must carry a response.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_pred <= 1'b0;
            d_upd  <= 1'b0;
        end else begin
            d_pred <= pred_valid_in;
            d_upd  <= upd_valid;
        end
    end

    // Monitor: samples on the falling edge, pops expectations when a response is due.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("a_pred_valid", a_pred_valid, d_pred);
            chk("b_pred_valid", b_pred_valid, d_pred);
            if (d_pred) begin
                if (exp_pa_q.size() == 0 || exp_pb_q.size() == 0) begin
                    chk("pred_queue_empty", 1, 0);
                end else begin
                    chk("a_pred", {a_pred_taken, a_pred_hist}, exp_pa_q.pop_front());
                    chk("b_pred", {b_pred_taken, b_pred_hist}, exp_pb_q.pop_front());
                end
            end
            if (d_upd) begin
                if (exp_ma_q.size() == 0 || exp_mb_q.size() == 0) begin
                    chk("mis_queue_empty", 1, 0);
                end else begin
                    chk("a_mispredict", a_upd_mis, exp_ma_q.pop_front());
                    chk("b_mispredict", b_upd_mis, exp_mb_q.pop_front());
                end
            end else begin
                chk("a_mispredict_idle", a_upd_mis, 0);
                chk("b_mispredict_idle", b_upd_mis, 0);
            end
        end
    end

    // One cycle of stimulus; called at posedge+1 and returns at the next posedge+1.
    task automatic step(input logic pv, input logic [K-1:0] ppc, input logic ta, input logic tb,
                        input logic [M-1:0] ph,
                        input logic uv, input logic [K-1:0] upc, input logic [M-1:0] uh,
                        input logic ut, input logic ma, input logic mb);
        pred_valid_in = pv;
        pred_pc       = ppc;
        upd_valid     = uv;
        upd_pc        = upc;
        upd_hist      = uh;
        upd_taken     = ut;
        if (pv) begin
            exp_pa_q.push_back({ta, ph});
            exp_pb_q.push_back({tb, ph});
        end
        if (uv) begin
            exp_ma_q.push_back(ma);
            exp_mb_q.push_back(mb);
`ifdef BP_PERF_CNT_EN
            exp_br++;
            exp_mis_a += int'(ma);
            exp_mis_b += int'(mb);
`endif
        end
        @(posedge clk);
        #1;
        pred_valid_in = 1'b0;
        upd_valid     = 1'b0;
    endtask

    task automatic predict(input logic [K-1:0] pc, input logic ta, input logic tb, input logic [M-1:0] h);
        step(1'b1, pc, ta, tb, h, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic update(input logic [K-1:0] pc, input logic [M-1:0] h, input logic t,
                          input logic ma, input logic mb);
        step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, pc, h, t, ma, mb);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        rst_n         = 1'b0;
        pred_valid_in = 1'b0;
        pred_pc       = '0;
        upd_valid     = 1'b0;
        upd_pc        = '0;
        upd_hist      = '0;
        upd_taken     = 1'b0;
`ifdef BP_PERF_CNT_EN
        exp_br = 0; exp_mis_a = 0; exp_mis_b = 0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_pred_valid", a_pred_valid, 0);
        chk("rst_pred_taken", a_pred_taken, 0);
        chk("rst_pred_hist", a_pred_hist, 0);
        chk("rst_mispredict", a_upd_mis, 0);
        chk("rst_ghr_a", a_ghr, 0);
        chk("rst_ghr_b", b_ghr, 0);
        @(posedge clk);
        #1;

        // Fresh counters are weakly not-taken.
        predict(8'h05, 1'b0, 1'b0, 4'h0);
        update(8'h05, 4'h0, 1'b1, 1'b1, 1'b1);
        update(8'h05, 4'h0, 1'b1, 1'b0, 1'b0);
        // Four not-taken updates elsewhere return the GHR to zero and floor those counters.
        for (int i = 0; i < 4; i++)
            update(8'h80, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("ghr_cleared", a_ghr, 4'h0);
        predict(8'h05, 1'b1, 1'b1, 4'h0);

        // Saturation at the top: five taken then one not-taken.
        update(8'h0A, 4'h0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++)
            update(8'h0A, 4'h0, 1'b1, 1'b0, 1'b0);
        update(8'h0A, 4'h0, 1'b0, 1'b1, 1'b1);
        chk("ghr_after_sat", a_ghr, 4'hE);
        // GHR=E: pc 0x04 lands on gshare index 0x0A (counter 2); concat index 0xE4.
        predict(8'h04, 1'b1, 1'b0, 4'hE);
        update(8'h0A, 4'h0, 1'b0, 1'b1, 1'b1);
        update(8'h0A, 4'h0, 1'b0, 1'b0, 1'b0);
        // GHR=8: pc 0x02 lands on gshare index 0x0A (counter 0); concat index 0x82.
        predict(8'h02, 1'b0, 1'b0, 4'h8);
        update(8'h0A, 4'h0, 1'b0, 1'b0, 1'b0);

        // Outcomes 1,0,1,1 build GHR=1011 while training index 0x04 to 3.
        update(8'h04, 4'h0, 1'b1, 1'b1, 1'b1);
        update(8'h60, 4'h0, 1'b0, 1'b0, 1'b0);
        update(8'h04, 4'h0, 1'b1, 1'b0, 1'b0);
        update(8'h04, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("ghr_1011_a", a_ghr, 4'hB);
        chk("ghr_1011_b", b_ghr, 4'hB);
        // pc 0x0F: gshare hits 0x04 (taken), concat hits 0xBF (untrained); back-to-back with pc 0x0A.
        predict(8'h0F, 1'b1, 1'b0, 4'hB);
        predict(8'h0A, 1'b0, 1'b0, 4'hB);

        // Drop index 0x04 to 2, then collide predict and not-taken update on it.
        update(8'h04, 4'h0, 1'b0, 1'b1, 1'b1);
        chk("ghr_pre_collide", a_ghr, 4'h6);
        step(1'b1, 8'h02, 1'b1, 1'b0, 4'h6, 1'b1, 8'h04, 4'h0, 1'b0, 1'b1, 1'b1);
        // GHR=C: pc 0x08 reaches gshare index 0x04, now 1.
        predict(8'h08, 1'b0, 1'b0, 4'hC);

        @(posedge clk);
        #1;
`ifdef BP_PERF_CNT_EN
        chk("perf_br_a", a_perf_br, exp_br);
        chk("perf_mis_a", a_perf_mis, exp_mis_a);
        chk("perf_br_b", b_perf_br, exp_br);
        chk("perf_mis_b", b_perf_mis, exp_mis_b);
`endif

        // Asynchronous reset between edges while a prediction is being presented.
        pred_valid_in = 1'b1;
        pred_pc       = 8'h05;
        @(posedge clk);
        #2;
        pred_valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_pred_valid_a", a_pred_valid, 0);
        chk("async_pred_valid_b", b_pred_valid, 0);
        chk("async_ghr", a_ghr, 0);
        chk("async_pred_hist", a_pred_hist, 0);
        chk("async_pred_taken", a_pred_taken, 0);
`ifdef BP_PERF_CNT_EN
        chk("async_perf_br", a_perf_br, 0);
        chk("async_perf_mis", a_perf_mis, 0);
        exp_br = 0; exp_mis_a = 0; exp_mis_b = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Index 0x05 was saturated taken before reset; it must be back to weakly not-taken.
        predict(8'h05, 1'b0, 1'b0, 4'h0);
        update(8'h05, 4'h0, 1'b1, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        chk("queues_drained", exp_pa_q.size() + exp_pb_q.size() + exp_ma_q.size() + exp_mb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
